// File: rtl/nq_bus_pkg.sv
// rtl/nq_bus_pkg.sv - shared types for the nqcpu memory bus and its arbiter
package nq_bus_pkg;

    localparam int NQ_AW = 16;
    localparam int NQ_DW = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic [NQ_AW-1:0] addr;
        logic             re;
        logic             we;
        logic [NQ_DW-1:0] wdata;
    } bus_req_t;

    function automatic owner_t other_of(input owner_t o);
        return (o == OWN_M0) ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/nq_bus_mux.sv
// rtl/nq_bus_mux.sv - combinational owner mux toward the slave and needWait fan-back
module nq_bus_mux
    import nq_bus_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  owner_t        owner_i,
    input  logic          en_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic          m0_re_i,
    input  logic          m0_we_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic          m1_re_i,
    input  logic          m1_we_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic          needwait_i,
    output logic [AW-1:0] addr_o,
    output logic          re_o,
    output logic          we_o,
    output logic [DW-1:0] wdata_o,
    output logic          m0_wait_o,
    output logic          m1_wait_o
);

    logic req0;
    logic req1;

    always_comb begin
        req0    = m0_re_i | m0_we_i;
        req1    = m1_re_i | m1_we_i;
        addr_o  = '0;
        re_o    = 1'b0;
        we_o    = 1'b0;
        wdata_o = '0;
        case (owner_i)
            OWN_M0: begin
                addr_o  = m0_addr_i;
                we_o    = m0_we_i;
                re_o    = m0_re_i & ~m0_we_i;
                wdata_o = m0_wdata_i;
            end
            OWN_M1: begin
                addr_o  = m1_addr_i;
                we_o    = m1_we_i;
                re_o    = m1_re_i & ~m1_we_i;
                wdata_o = m1_wdata_i;
            end
            default: ;
        endcase
        // A requesting non-owner always stalls; the owner sees the slave's busy.
        m0_wait_o = en_i & req0 & ((owner_i == OWN_M0) ? needwait_i : 1'b1);
        m1_wait_o = en_i & req1 & ((owner_i == OWN_M1) ? needwait_i : 1'b1);
    end

endmodule

// File: rtl/nq_bus_arbiter.sv
// rtl/nq_bus_arbiter.sv - two-master round-robin arbiter for the nqcpu memory bus
module nq_bus_arbiter
    import nq_bus_pkg::*;
#(
    parameter int BURST = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] m0_addr_i,
    input  logic          m0_re_i,
    input  logic          m0_we_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_wait_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic [AW-1:0] m1_addr_i,
    input  logic          m1_re_i,
    input  logic          m1_we_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_wait_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] addr_o,
    output logic          re_o,
    output logic          we_o,
    output logic [DW-1:0] wdata_o,
    input  logic [DW-1:0] rdata_i,
    input  logic          needWait_i,
    output logic [1:0]    grant_o
);

    localparam int CW = $clog2(BURST + 1);

    owner_t        owner_q, owner_d;
    owner_t        rr_last_q, rr_last_d;
    owner_t        oth;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          req0, req1, own_req, oth_req, burst_done;

    always_comb begin
        req0       = m0_re_i | m0_we_i;
        req1       = m1_re_i | m1_we_i;
        oth        = other_of(owner_q);
        own_req    = (owner_q == OWN_M0) ? req0 : ((owner_q == OWN_M1) ? req1 : 1'b0);
        oth_req    = (owner_q == OWN_M0) ? req1 : req0;
        burst_done = ({1'b0, hold_cnt_q} + (CW+1)'(1)) >= (CW+1)'(BURST);
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        hold_cnt_d = hold_cnt_q;
        case (owner_q)
            OWN_NONE: begin
                if (req0 && req1)
                    owner_d = other_of(rr_last_q);
                else if (req0)
                    owner_d = OWN_M0;
                else if (req1)
                    owner_d = OWN_M1;
            end
            default: begin
                if (!own_req) begin
                    // Owner let go, with or without completing: hand over or idle.
                    owner_d = oth_req ? oth : OWN_NONE;
                end else if (!needWait_i) begin
                    if (hold_cnt_q != CW'(BURST))
                        hold_cnt_d = hold_cnt_q + CW'(1);
                    if (oth_req && burst_done)
                        owner_d = oth;
                end
            end
        endcase
        if (owner_d != owner_q) begin
            hold_cnt_d = '0;
            if (owner_q != OWN_NONE)
                rr_last_d = owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            rr_last_q  <= OWN_M1;
            hold_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant_o    = {owner_q == OWN_M1, owner_q == OWN_M0};
    assign m0_rdata_o = rdata_i;
    assign m1_rdata_o = rdata_i;

    nq_bus_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .owner_i    (owner_q),
        .en_i       (rst_n),
        .m0_addr_i  (m0_addr_i),
        .m0_re_i    (m0_re_i),
        .m0_we_i    (m0_we_i),
        .m0_wdata_i (m0_wdata_i),
        .m1_addr_i  (m1_addr_i),
        .m1_re_i    (m1_re_i),
        .m1_we_i    (m1_we_i),
        .m1_wdata_i (m1_wdata_i),
        .needwait_i (needWait_i),
        .addr_o     (addr_o),
        .re_o       (re_o),
        .we_o       (we_o),
        .wdata_o    (wdata_o),
        .m0_wait_o  (m0_wait_o),
        .m1_wait_o  (m1_wait_o)
    );

endmodule

// File: tb/tb_nq_bus_arbiter.sv
// tb/tb_nq_bus_arbiter.sv - directed scoreboard bench for nq_bus_arbiter
module tb_nq_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] m0_addr_i = 16'h0010, m1_addr_i = 16'h0200;
    logic [15:0] m0_wdata_i = 16'h1111, m1_wdata_i = 16'h2222;
    logic        m0_re_i = 1'b0, m0_we_i = 1'b0, m1_re_i = 1'b0, m1_we_i = 1'b0;
    logic        m0_wait_o, m1_wait_o, re_o, we_o, needWait_i = 1'b0;
    logic [15:0] m0_rdata_o, m1_rdata_o, addr_o, wdata_o, rdata_i = 16'h0;
    logic [1:0]  grant_o;

    typedef struct packed {
        logic [1:0]  g;
        logic [15:0] addr;
        logic        re;
        logic        we;
        logic [15:0] wd;
        logic        w0;
        logic        w1;
        logic [15:0] rd0;
        logic [15:0] rd1;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    string tname = "";
    int    n_vec = 0;
    int    n_bad = 0;
    int    vidx  = 0;

    always #5 clk = ~clk;

    nq_bus_arbiter #(.BURST(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(m0_addr_i), .m0_re_i(m0_re_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
        .m0_wait_o(m0_wait_o), .m0_rdata_o(m0_rdata_o),
        .m1_addr_i(m1_addr_i), .m1_re_i(m1_re_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
        .m1_wait_o(m1_wait_o), .m1_rdata_o(m1_rdata_o),
        .addr_o(addr_o), .re_o(re_o), .we_o(we_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i), .needWait_i(needWait_i), .grant_o(grant_o)
    );

    task automatic vec(input logic rstv, input logic r0, input logic w0, input logic r1,
                       input logic w1, input logic nw, input logic [1:0] eg,
                       input logic [15:0] ea, input logic ere, input logic ewe,
                       input logic [15:0] ewd, input logic ew0, input logic ew1);
        obs_t        e;
        logic [15:0] rd;
        @(posedge clk);
        #1;
        rd         = 16'hA000 ^ 16'(vidx);
        rst_n      = rstv;
        m0_re_i    = r0;
        m0_we_i    = w0;
        m1_re_i    = r1;
        m1_we_i    = w1;
        needWait_i = nw;
        rdata_i    = rd;
        e = '{g: eg, addr: ea, re: ere, we: ewe, wd: ewd, w0: ew0, w1: ew1, rd0: rd, rd1: rd};
        exp_q.push_back(e);
        name_q.push_back($sformatf("%s#%0d", tname, vidx));
        vidx++;
    endtask

    always @(negedge clk) begin
        obs_t  e, a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{g: grant_o, addr: addr_o, re: re_o, we: we_o, wd: wdata_o,
                   w0: m0_wait_o, w1: m1_wait_o, rd0: m0_rdata_o, rd1: m1_rdata_o};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got g=%b a=%h re=%b we=%b wd=%h w=%b%b rd=%h/%h, want g=%b a=%h re=%b we=%b wd=%h w=%b%b rd=%h/%h",
                         nm, a.g, a.addr, a.re, a.we, a.wd, a.w0, a.w1, a.rd0, a.rd1,
                         e.g, e.addr, e.re, e.we, e.wd, e.w0, e.w1, e.rd0, e.rd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        tname = "reset";
        vec(0, 1,0,1,0, 1, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);

        tname = "m0_read";
        vec(1, 1,0,0,0, 1, 2'b00, 16'h0000, 0,0, 16'h0000, 1,0);
        vec(1, 1,0,0,0, 1, 2'b01, 16'h0010, 1,0, 16'h1111, 1,0);
        vec(1, 1,0,0,0, 1, 2'b01, 16'h0010, 1,0, 16'h1111, 1,0);
        vec(1, 1,0,0,0, 0, 2'b01, 16'h0010, 1,0, 16'h1111, 0,0);
        vec(1, 0,0,0,0, 0, 2'b01, 16'h0010, 0,0, 16'h1111, 0,0);
        vec(1, 0,0,0,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);
        vec(0, 0,0,0,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);

        tname = "tie";
        vec(1, 1,0,1,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 1,1);
        vec(1, 1,0,1,0, 1, 2'b01, 16'h0010, 1,0, 16'h1111, 1,1);
        vec(1, 1,0,1,0, 0, 2'b01, 16'h0010, 1,0, 16'h1111, 0,1);
        vec(1, 0,0,1,0, 0, 2'b01, 16'h0010, 0,0, 16'h1111, 0,1);
        vec(1, 0,0,1,0, 0, 2'b10, 16'h0200, 1,0, 16'h2222, 0,0);
        vec(1, 0,0,0,0, 0, 2'b10, 16'h0200, 0,0, 16'h2222, 0,0);
        vec(1, 0,0,0,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);

        tname = "burst";
        vec(1, 1,0,1,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 1,1);
        for (int i = 0; i < 12; i++) begin
            if (((i / 4) % 2) == 0)
                vec(1, 1,0,1,0, 0, 2'b01, 16'h0010, 1,0, 16'h1111, 0,1);
            else
                vec(1, 1,0,1,0, 0, 2'b10, 16'h0200, 1,0, 16'h2222, 1,0);
        end
        vec(1, 0,0,0,0, 0, 2'b10, 16'h0200, 0,0, 16'h2222, 0,0);
        vec(1, 0,0,0,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);

        tname = "rw_both";
        m1_addr_i  = 16'h0300;
        m1_wdata_i = 16'hBEEF;
        vec(1, 0,0,1,1, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,1);
        vec(1, 0,0,1,1, 0, 2'b10, 16'h0300, 0,1, 16'hBEEF, 0,0);
        vec(1, 0,0,0,0, 0, 2'b10, 16'h0300, 0,0, 16'hBEEF, 0,0);
        vec(1, 0,0,0,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);

        tname = "drop";
        vec(1, 1,0,0,0, 1, 2'b00, 16'h0000, 0,0, 16'h0000, 1,0);
        vec(1, 1,0,1,0, 1, 2'b01, 16'h0010, 1,0, 16'h1111, 1,1);
        vec(1, 0,0,1,0, 1, 2'b01, 16'h0010, 0,0, 16'h1111, 0,1);
        vec(1, 0,0,1,0, 1, 2'b10, 16'h0300, 1,0, 16'hBEEF, 0,1);

        tname = "mid_reset";
        vec(0, 1,0,1,0, 1, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);
        vec(1, 1,0,1,0, 1, 2'b00, 16'h0000, 0,0, 16'h0000, 1,1);
        vec(1, 1,0,1,0, 0, 2'b01, 16'h0010, 1,0, 16'h1111, 0,1);
        vec(1, 0,0,0,0, 0, 2'b01, 16'h0010, 0,0, 16'h1111, 0,0);
        vec(1, 0,0,0,0, 0, 2'b00, 16'h0000, 0,0, 16'h0000, 0,0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nq_bus_arbiter.md
# nq_bus_arbiter

Two-master arbiter that shares the single nqcpu memory bus (addr/re/we with slave-driven needWait) between master 0 (CPU) and master 1 (DMA/debug loader). The owner is registered. Slave-side signals are muxed from the owner combinationally. Grant rotates round-robin on transaction boundaries, and an owner may hold the bus for at most BURST back-to-back transactions while the other master waits. The block sits between the masters and the ROM/RAM slave. Data is split in/out; no tri-state.

## Interface
- BURST, 4, max consecutive completed transactions by one owner while the other master is requesting (≥1)
- AW, 16, address width
- DW, 16, data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_addr_i / m1_addr_i  in  AW  master address
- m0_re_i / m1_re_i  in  1  read request, held until completion
- m0_we_i / m1_we_i  in  1  write request, held until completion
- m0_wdata_i / m1_wdata_i  in  DW  write data
- m0_wait_o / m1_wait_o  out  1  needWait back to master
- m0_rdata_o / m1_rdata_o  out  DW  read data (rdata_i broadcast to both)
- addr_o  out  AW  slave address
- re_o / we_o  out  1  slave strobes
- wdata_o  out  DW  slave write data
- rdata_i  in  DW  slave read data
- needWait_i  in  1  slave busy
- grant_o  out  2  one-hot owner {m1,m0}; 00 = idle

## Operation
- Master request: req_k = re_k | we_k.
- Completion: a cycle with owner req high and needWait_i low; the master samples rdata on that edge.
- State is owner ∈ {NONE, M0, M1}, plus:
  - rr_last: last owner; reset value M1, so M0 wins the first tie.
  - hold_cnt: completions by the current owner; width $clog2(BURST+1).
- NONE, nothing requested: stay.
- NONE, one request: go to that master.
- NONE, both request: go to the master ≠ rr_last.
- M0/M1 on completion:
  - hold_cnt++.
  - If the other master requests and (hold_cnt+1 == BURST, or owner req is low next), switch directly to the other master; no idle cycle.
  - If neither requests, go to NONE.
  - Otherwise stay.
- Owner drops req without completing (protocol error): release. Go to the other master if it requests, else NONE. No counter increment.
- On any owner change: hold_cnt ← 0, rr_last ← previous owner.
- Slave outputs:
  - Owner NONE: all slave outputs are 0.
  - Otherwise, the owner's addr and wdata are passed through.
  - we_o = owner we.
  - re_o = owner re & ~owner we (write wins if both are set).
- mk_wait_o:
  - 0 if the master is not requesting.
  - needWait_i if the master is the owner.
  - 1 if the master is requesting but not the owner.
- grant_o reflects the registered owner.

## Timing
- Reset (async assert, sync-safe deassert): owner = NONE, hold_cnt = 0, rr_last = M1. All outputs are 0 (addr_o, re_o, we_o, wdata_o, grant_o, both waits).
- Reset mid-transaction aborts it; the slave sees strobes drop in the same cycle.
- Grant latency from idle: request in cycle N; wait=1 in N; slave strobes and grant in N+1.
- Zero-wait slave: a lone master sees one wait cycle, then one transaction per cycle.
- Handover: completion in cycle N; new owner's strobes in N+1.
  - The old owner, if it re-requests in N+1, sees wait=1.
- needWait_i is ignored while owner is NONE.
- Counter saturation: with BURST=1, the grant alternates every transaction when both masters request.

## Structure
- Shared package nq_bus_pkg:
  - typedef enum owner_t {OWN_NONE, OWN_M0, OWN_M1};
  - bus_req_t struct {addr, re, we, wdata}, reused by the nqcpu bus masters.
- One sub-module, nq_bus_mux: pure combinational owner mux and wait generation.
- The arbiter FSM and counters stay in the top module.

## Test plan
- M0 reads 0x0010 alone; slave holds needWait 2 cycles → addr_o=0x0010 from cycle 1; m0_wait_o = 1,1,1,0; rdata delivered; grant_o=01 then 00.
- Both request in the same cycle after reset → M0 is granted first. M1 wait=1 until M0 completes, then M1 is driven the next cycle (grant_o 01→10, no 00 gap).
- BURST=4, both continuously requesting, zero-wait slave → grant pattern is 4×M0, 4×M1, repeating. Check hold_cnt resets at each switch.
- M1 asserts re and we together, wdata=0xBEEF → we_o=1, re_o=0, wdata_o=0xBEEF.
- M0 owner drops re while needWait_i=1 → next cycle grant_o switches to M1 (if requesting) or 00. No completion is counted.
- Assert rst_n low mid-transaction with needWait_i=1 → all outputs 0 immediately (async). After release, the first tie goes to M0.
